muldiv_unit: RTL
================

# muldiv_unit

Iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the execute stage. It sits beside the ALU and shares the execute stage's func3 decode. Width is parametrised, and every operation completes with a fixed latency using a start/busy/done handshake. The pipeline stalls on busy and supports a synchronous flush for squashed instructions.

## Interface
- XLEN, 32, operand and result width (must be ≥ 4)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only in IDLE or DONE
- flush  in  1  synchronous abort; overrides start
- func3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  in  XLEN  rs1 value (multiplicand/dividend)
- op_b  in  XLEN  rs2 value (multiplier/divisor)
- busy  out  1  high in CALC or FIX
- done  out  1  high exactly in DONE (one cycle per op)
- result  out  XLEN  registered result; held until next completion

## Operation
- States: IDLE, CALC, FIX, DONE. Reset → IDLE; busy=0, done=0, result=0, internal registers 0.
- IDLE/DONE + start (no flush): latch func3, sign flags, magnitudes |op_a|,|op_b| and the raw op_a; count=0; → CALC. DONE without start → IDLE.
- Signedness: op_a signed for MULH, MULHSU, DIV, REM; op_b signed for MULH, DIV, REM. Otherwise unsigned. Magnitude of the most negative value = 2^(XLEN-1) as an unsigned XLEN value.
- CALC, multiply: radix-2 shift-add into a 2·XLEN unsigned accumulator, one multiplier bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle. Uses an XLEN+1-bit partial remainder.
- count increments each CALC cycle. After XLEN iterations → FIX.
- FIX (one cycle) writes result:
  - MUL: low XLEN bits of the signed-corrected product. MULH/MULHSU/MULHU: high XLEN bits.
  - Product negated (2·XLEN two's complement) when the operand signs differ.
  - DIV quotient negated when sign_a≠sign_b. REM remainder takes sign_a.
  - Divisor zero overrides: DIV/DIVU = all ones, REM/REMU = raw op_a.
  - Overflow (DIV of min by −1) needs no special case: the magnitude path yields quotient = min, remainder 0.
  - → DONE.
- flush in any state → IDLE next edge. done stays 0 and result is unchanged. A flush with start in the same cycle drops the start.
- start while busy: ignored, with no side effects.

## Timing
- Accepting edge = edge 0. CALC spans edges 1..XLEN. The FIX→DONE transition is at edge XLEN+1.
- busy high from edge 0 until edge XLEN+1.
- done high from edge XLEN+1 to XLEN+2. result is valid from edge XLEN+1.
- Latency is fixed at XLEN+1 cycles for every op, including divide-by-zero.
- Back-to-back: start in DONE is accepted at edge XLEN+2, so throughput is one op per XLEN+2 cycles.
- result changes only at the FIX→DONE edge or on reset.
- Asynchronous reset mid-operation: immediate IDLE, outputs zero, no done.

## Test plan
- MUL with XLEN=32: op_a=7, op_b=0xFFFFFFFD -> result 0xFFFFFFEB; done at edge 33 only; busy high for cycles 0..32.
- Multiply high-half ops -> required results:
  - MULH 0x80000000×0x80000000 -> 0x40000000
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE
  - MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF
- DIV and REM:
  - DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD
  - REM 0xFFFFFFF9/2 -> 0xFFFFFFFF
  - DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC
- Corner cases:
  - DIV 5/0 -> 0xFFFFFFFF
  - REMU 5/0 -> 5
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000
  - REM 0x80000000/0xFFFFFFFF -> 0
- Handshake:
  - start pulsed at cycle 5 of a busy op -> ignored, first result unaffected.
  - start held in DONE -> second op accepted, done at edge 2·34−1.
- Abort:
  - flush at cycle 10 -> IDLE, no done, result keeps prior value; a new op then completes correctly.
  - rst asserted mid-CALC -> busy, done and result all 0 immediately.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, fixed XLEN+1 cycle latency behind a start/busy/done handshake.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(XLEN - 1);
  localparam logic [CW-1:0] COUNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t state_r, state_s;

  logic [2:0]        func_r;
  logic              sign_a_r, sign_b_r;
  logic [XLEN-1:0]   mag_a_r, mag_b_r, raw_a_r;
  logic [CW-1:0]     count_r;
  logic [2*XLEN-1:0] acc_r;
  logic [XLEN-1:0]   rem_r;
  logic [XLEN-1:0]   result_r;
  logic              busy_r, done_r;

  function automatic logic a_is_signed(input logic [2:0] f);
    case (f)
      3'b001, 3'b010, 3'b100, 3'b110: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic logic b_is_signed(input logic [2:0] f);
    case (f)
      3'b001, 3'b100, 3'b110: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
    return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
  endfunction

  logic              accept_s;
  logic              in_sign_a_s, in_sign_b_s;
  logic [XLEN-1:0]   in_mag_a_s, in_mag_b_s;
  logic [XLEN:0]     mul_sum_s;
  logic [2*XLEN-1:0] mul_next_s;
  logic [XLEN:0]     div_shift_s, div_diff_s, div_rem_next_s;
  logic [XLEN-1:0]   div_quo_next_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;
  logic              div_zero_s;
  logic [XLEN-1:0]   fix_result_s;

  assign accept_s    = start && !flush && (state_r == IDLE || state_r == DONE);
  assign in_sign_a_s = a_is_signed(func3) && op_a[XLEN-1];
  assign in_sign_b_s = b_is_signed(func3) && op_b[XLEN-1];
  assign in_mag_a_s  = in_sign_a_s ? neg_x(op_a) : op_a;
  assign in_mag_b_s  = in_sign_b_s ? neg_x(op_b) : op_b;

  // Multiply keeps {partial high, unconsumed multiplier} in acc; divide keeps the
  // unconsumed dividend / growing quotient in the low half of acc.
  assign mul_sum_s      = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, mag_a_r} : {(XLEN+1){1'b0}});
  assign mul_next_s     = {mul_sum_s, acc_r[XLEN-1:1]};
  assign div_shift_s    = {rem_r, acc_r[XLEN-1]};
  assign div_diff_s     = div_shift_s - {1'b0, mag_b_r};
  assign div_rem_next_s = div_diff_s[XLEN] ? div_shift_s : div_diff_s;
  assign div_quo_next_s = {acc_r[XLEN-2:0], ~div_diff_s[XLEN]};

  assign prod_s     = (sign_a_r ^ sign_b_r) ? neg_2x(acc_r) : acc_r;
  assign quo_s      = (sign_a_r ^ sign_b_r) ? neg_x(acc_r[XLEN-1:0]) : acc_r[XLEN-1:0];
  assign rem_s      = sign_a_r ? neg_x(rem_r) : rem_r;
  assign div_zero_s = (mag_b_r == {XLEN{1'b0}});

  // Final sign correction and divide-by-zero overrides applied in FIX
  always_comb begin
    fix_result_s = result_r;
    case (func_r)
      3'b000:                 fix_result_s = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_result_s = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_result_s = div_zero_s ? {XLEN{1'b1}} : quo_s;
      3'b110, 3'b111:         fix_result_s = div_zero_s ? raw_a_r : rem_s;
      default:                fix_result_s = result_r;
    endcase
  end

  // Next-state logic; flush wins over every transition
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = CALC;
        else          state_s = IDLE;
      end
      CALC: begin
        if (count_r == LAST_COUNT) state_s = FIX;
        else                       state_s = CALC;
      end
      FIX:     state_s = DONE;
      DONE: begin
        if (accept_s) state_s = CALC;
        else          state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
    if (flush) begin
      state_s = IDLE;
    end else begin
      state_s = state_s;
    end
  end

  // State register and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == CALC) || (state_s == FIX);
      done_r  <= (state_s == DONE);
    end
  end

  // Operand capture, iteration datapath and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      func_r   <= 3'b000;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      mag_a_r  <= {XLEN{1'b0}};
      mag_b_r  <= {XLEN{1'b0}};
      raw_a_r  <= {XLEN{1'b0}};
      count_r  <= {CW{1'b0}};
      acc_r    <= {(2*XLEN){1'b0}};
      rem_r    <= {XLEN{1'b0}};
      result_r <= {XLEN{1'b0}};
    end else if (flush) begin
      count_r <= {CW{1'b0}};
    end else if (accept_s) begin
      func_r   <= func3;
      sign_a_r <= in_sign_a_s;
      sign_b_r <= in_sign_b_s;
      mag_a_r  <= in_mag_a_s;
      mag_b_r  <= in_mag_b_s;
      raw_a_r  <= op_a;
      count_r  <= {CW{1'b0}};
      rem_r    <= {XLEN{1'b0}};
      acc_r    <= func3[2] ? {{XLEN{1'b0}}, in_mag_a_s} : {{XLEN{1'b0}}, in_mag_b_s};
    end else if (state_r == CALC) begin
      count_r <= count_r + COUNT_ONE;
      if (func_r[2]) begin
        rem_r             <= div_rem_next_s[XLEN-1:0];
        acc_r[XLEN-1:0]   <= div_quo_next_s;
      end else begin
        acc_r <= mul_next_s;
      end
    end else if (state_r == FIX) begin
      result_r <= fix_result_s;
    end else begin
      result_r <= result_r;
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule
